// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, the HI/LO pair
// type and the helper that decides which ops launch a multi-cycle operation.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // Only the four arithmetic ops occupy the unit; everything else completes in EX.
  function automatic logic is_launch_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit. The result is computed behaviourally at launch
// and parked in a stage register; a down-counter models the latency, and HI/LO
// only update when the counter expires, on MTHI/MTLO, or on reset.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  hilo_t            r_stage;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_dsor_s;
  logic [31:0] w_dsor_u;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;
  hilo_t       w_stage_nxt;
  logic        w_is_mul;

  // The low 64 bits of a product of sign-extended operands equal the signed product.
  assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide on magnitudes: avoids the INT_MIN / -1 overflow case entirely,
  // since 0x80000000 / 1 negated back is 0x80000000 with remainder 0.
  assign w_a_neg  = A[31];
  assign w_b_neg  = B[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - A) : A;
  assign w_b_mag  = w_b_neg ? (32'd0 - B) : B;
  // A zero divisor is replaced by 1 only to keep the datapath X-free; its result is discarded.
  assign w_dsor_s = (B == 32'd0) ? 32'd1 : w_b_mag;
  assign w_dsor_u = (B == 32'd0) ? 32'd1 : B;
  assign w_q_mag  = w_a_mag / w_dsor_s;
  assign w_r_mag  = w_a_mag % w_dsor_s;
  assign w_q_s    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r_s    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
  assign w_q_u    = A / w_dsor_u;
  assign w_r_u    = A % w_dsor_u;

  assign w_is_mul = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU);

  // Select the value HI/LO will take at completion; divide by zero keeps HI/LO as they are.
  always_comb begin
    w_stage_nxt = '0;
    case (mdu_op)
      MDU_MULT:  w_stage_nxt = w_prod_s;
      MDU_MULTU: w_stage_nxt = w_prod_u;
      MDU_DIV:   w_stage_nxt = (B == 32'd0) ? {r_hi, r_lo} : {w_r_s, w_q_s};
      MDU_DIVU:  w_stage_nxt = (B == 32'd0) ? {r_hi, r_lo} : {w_r_u, w_q_u};
      default:   w_stage_nxt = '0;
    endcase
  end

  // Control FSM plus HI/LO: launch from idle, count down, commit the stage on expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_stage <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start && is_launch_op(mdu_op)) begin
            r_stage <= w_stage_nxt;
            r_cnt   <= w_is_mul ? MUL_CNT : DIV_CNT;
            r_state <= w_is_mul ? StMul : StDiv;
          end else if (mdu_op == MDU_MTHI) begin
            r_hi <= A;
          end else if (mdu_op == MDU_MTLO) begin
            r_lo <= A;
          end
        end
        StMul, StDiv: begin
          if (r_cnt == '0) begin
            r_hi    <= r_stage.hi;
            r_lo    <= r_stage.lo;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy = (r_state != StIdle);
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Read port into the EX result mux; always the architectural HI/LO, never the stage.
  always_comb begin
    result = '0;
    case (mdu_op)
      MDU_MFHI: result = r_hi;
      MDU_MFLO: result = r_lo;
      default:  result = '0;
    endcase
  end

endmodule
